// File: rtl/digit_marquee_ctrl_if.sv
// Control/data bundle between a marquee controller and its user: animation controls and edits in, packed digits/blank/tick out.
interface digit_marquee_ctrl_if #(
  parameter int unsigned DIGITS = 8
);
  logic [1:0]          speed;
  logic [1:0]          mode;
  logic                dir;
  logic                blink_en;
  logic [DIGITS-1:0]   inc;
  logic [DIGITS-1:0]   dec;
  logic                load;
  logic [4*DIGITS-1:0] load_value;
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   blank;
  logic                tick;

  modport master (
    output speed, mode, dir, blink_en, inc, dec, load, load_value,
    input  digits, blank, tick
  );

  modport slave (
    input  speed, mode, dir, blink_en, inc, dec, load, load_value,
    output digits, blank, tick
  );
endinterface

// File: rtl/digit_marquee_ctrl.sv
// Hex-digit pattern engine: per-digit edit, rotate/bounce/wave animation on a prescaled tick, and blink mask.
// All outputs registered; inputs take effect one cycle later; no backpressure (free-running display path).
module digit_marquee_ctrl #(
  parameter int unsigned         DIGITS      = 8,
  parameter int unsigned         DIV_BASE    = 25_000_000,
  parameter logic [4*DIGITS-1:0] RESET_VALUE = 32'h1234_5678
) (
  input logic                 clk,
  input logic                 reset,
  digit_marquee_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DIV_BASE * 8) + 1;
  localparam int unsigned POS_W = $clog2(DIGITS);
  localparam int unsigned DW    = 4 * DIGITS;

  typedef enum logic [1:0] {
    M_EDIT   = 2'd0,
    M_ROTATE = 2'd1,
    M_BOUNCE = 2'd2,
    M_WAVE   = 2'd3
  } mode_e;

  mode_e            mode;
  mode_e            mode_q;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_int;
  logic             tick_q;
  logic [DW-1:0]    dig_q, dig_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             bdir_q, bdir_d;
  logic [1:0]       phase_q, phase_d;
  logic             bphase_q, bphase_d;
  logic [DIGITS-1:0] blank_q;
  logic             bounce_entry;

  function automatic logic [DW-1:0] rot_left(input logic [DW-1:0] d);
    return {d[DW-5:0], d[DW-1 -: 4]};
  endfunction

  function automatic logic [DW-1:0] rot_right(input logic [DW-1:0] d);
    return {d[3:0], d[DW-1:4]};
  endfunction

  function automatic logic [3:0] wave_nib(input logic [1:0] k);
    case (k)
      2'd0:    return 4'hD;
      2'd1:    return 4'hE;
      2'd2:    return 4'hF;
      default: return 4'hE;
    endcase
  endfunction

  assign mode = mode_e'(bus.mode);

  // >= rather than == so lowering the period below the current count fires at once.
  assign period   = CNT_W'(DIV_BASE) << (2'd3 - bus.speed);
  assign tick_int = (cnt_q >= (period - CNT_W'(1)));

  assign bounce_entry = (mode == M_BOUNCE) && (mode_q != M_BOUNCE);

  always_comb begin
    cnt_d    = tick_int ? '0 : cnt_q + CNT_W'(1);
    dig_d    = dig_q;
    pos_d    = pos_q;
    bdir_d   = bdir_q;
    phase_d  = phase_q;
    bphase_d = bus.blink_en ? (bphase_q ^ tick_int) : 1'b0;

    if (bus.load) begin
      dig_d = bus.load_value;
      if (mode == M_BOUNCE) begin
        pos_d = '0;
        if (bounce_entry) begin
          bdir_d = bus.dir;
        end
      end
    end else begin
      case (mode)
        M_EDIT: begin
          for (int i = 0; i < int'(DIGITS); i++) begin
            if (bus.inc[i] && !bus.dec[i]) begin
              dig_d[4*i +: 4] = dig_q[4*i +: 4] + 4'd1;
            end else if (bus.dec[i] && !bus.inc[i]) begin
              dig_d[4*i +: 4] = dig_q[4*i +: 4] - 4'd1;
            end
          end
        end
        M_ROTATE: begin
          if (tick_int) begin
            dig_d = bus.dir ? rot_left(dig_q) : rot_right(dig_q);
          end
        end
        M_BOUNCE: begin
          // Entry cycle only latches direction and clears position; stepping starts afterwards.
          if (bounce_entry) begin
            bdir_d = bus.dir;
            pos_d  = '0;
          end else if (tick_int) begin
            dig_d = bdir_q ? rot_left(dig_q) : rot_right(dig_q);
            if (pos_q == POS_W'(DIGITS - 2)) begin
              pos_d  = '0;
              bdir_d = ~bdir_q;
            end else begin
              pos_d = pos_q + POS_W'(1);
            end
          end
        end
        default: begin
          if (tick_int) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
              dig_d[4*i +: 4] = wave_nib(2'(i) + phase_q);
            end
            phase_d = phase_q + 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      dig_q    <= RESET_VALUE;
      pos_q    <= '0;
      bdir_q   <= 1'b0;
      phase_q  <= 2'd0;
      bphase_q <= 1'b0;
      blank_q  <= '0;
      mode_q   <= M_EDIT;
    end else begin
      cnt_q    <= cnt_d;
      tick_q   <= tick_int;
      dig_q    <= dig_d;
      pos_q    <= pos_d;
      bdir_q   <= bdir_d;
      phase_q  <= phase_d;
      bphase_q <= bphase_d;
      blank_q  <= {DIGITS{bphase_d}};
      mode_q   <= mode;
    end
  end

  assign bus.digits = dig_q;
  assign bus.blank  = blank_q;
  assign bus.tick   = tick_q;

endmodule

// File: doc/digit_marquee_ctrl.md
# digit_marquee_ctrl

Parametrised digit-pattern engine for the multi-digit seven-segment display path. Holds DIGITS hex nibbles and edits them from debounced per-digit increment/decrement pulses. Animates them by rotation, ping-pong bounce or a wave pattern, paced by an internal speed-selectable tick. Its packed output feeds the scanning display driver, and its blank mask implements blinking.

## Interface

Parameters:
- DIGITS, 8, number of hex digits (2..16)
- DIV_BASE, 25_000_000, tick period in clk cycles at speed 3; simulation uses 4
- RESET_VALUE, 32'h1234_5678, digit value after reset, width 4*DIGITS

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- speed  in  2  tick rate select; period = DIV_BASE << (3 - speed) cycles
- mode  in  2  00 EDIT, 01 ROTATE, 10 BOUNCE, 11 WAVE
- dir  in  1  1 = rotate toward MS digit (left), 0 = toward LS digit (right)
- blink_en  in  1  enable blink
- inc  in  DIGITS  one-cycle debounced pulses; bit i increments digit i
- dec  in  DIGITS  one-cycle debounced pulses; bit i decrements digit i
- load  in  1  load load_value into the digits
- load_value  in  4*DIGITS  value for load
- digits  out  4*DIGITS  packed digits; digit i at [4i+3:4i]; registered
- blank  out  DIGITS  per-digit blank mask for the display driver; registered
- tick  out  1  one-cycle pulse per animation step; registered

## Operation

- Prescaler: counts clk cycles. When count >= period-1, tick_int fires and count returns to 0. The >= comparison means a speed change mid-count never stalls.
- Priority per edge: reset > load > mode action.
- EDIT mode, applied every clk edge, not gated by tick:
  - inc[i] adds 1 to digit i, mod 16 (F→0).
  - dec[i] subtracts 1 from digit i, mod 16 (0→F).
  - inc[i] and dec[i] in the same cycle leave digit i unchanged.
  - All digits are independent; there is no carry.
- In every mode except EDIT, inc and dec are ignored.
- ROTATE mode, on tick_int:
  - dir=1: {d[N-2:0], d[N-1]}.
  - dir=0: {d[0], d[N-1:1]}.
- BOUNCE mode, on tick_int:
  - Rotates using the internal direction bdir, then increments pos.
  - When pos reaches DIGITS-1, pos returns to 0 and bdir inverts.
  - On the first cycle mode==BOUNCE after any other mode (tracked with registered mode_q), bdir loads from dir and pos clears. No step is taken on that entry cycle.
- WAVE mode, on tick_int:
  - Digit i = P[(i + phase) mod 4], where P = {D, E, F, E} (P[0]=D), using the pre-increment phase.
  - phase then increments mod 4.
  - Leaving WAVE keeps the last pattern.
- Blink:
  - With blink_en=1, bphase toggles on each tick_int and blank = {DIGITS{bphase}}.
  - With blink_en=0, bphase clears and blank = 0 on the next edge.
- load: digits <= load_value. In BOUNCE it also clears pos. The prescaler keeps running.

## Timing

- Reset values:
  - digits = RESET_VALUE, blank = 0, tick = 0.
  - prescaler = 0, bphase = 0, wave phase = 0, pos = 0, bdir = 0, mode_q = EDIT.
- Edit latency: an inc/dec sampled at edge k is visible on digits after edge k (1 cycle).
- Animation: the step is applied at the same edge that registers tick=1. The new digits and tick are visible together for exactly one cycle.
- The first tick after reset appears period cycles after reset deasserts.
- Tick spacing: exactly period cycles while speed is constant.
- A mode change takes effect at the next edge; no partial step occurs.
- reset mid-animation restores all reset values at the next edge, irrespective of other inputs.
- load coinciding with tick_int: load wins, and tick still pulses.

## Test plan

- Reset and idle: reset 1 cycle, mode=EDIT, DIGITS=8 → digits=0x12345678, blank=0, tick=0. With DIV_BASE=4 and speed=3, tick pulses every 4 cycles.
- Edit wrap and conflict:
  - inc[0] with digit0=F → 0.
  - dec[7] with digit7=0 → F.
  - inc[3]&dec[3] together → digit3 unchanged.
  - inc pulses in ROTATE → ignored.
- Rotate: mode=ROTATE, dir=1, speed=3 → after the first tick digits=0x23456781. Switch to dir=0 → next tick 0x12345678.
- Bounce: mode=BOUNCE, dir=1 from 0x12345678 → 7 left steps reach 0x81234567. The 8th tick goes right → 0x78123456. A load of 0xAAAA0000 mid-run → digits=0xAAAA0000 and pos=0.
- Wave and blink:
  - mode=WAVE → first tick digits=0xEFEDEFED (digit0=D). Second tick 0xDEFEDEFE.
  - blink_en=1 → blank toggles FF/00 on each tick.
- Speed change and reset: speed 0 (period 32) switched to 3 at count 20 → tick on the next cycle, then every 4 cycles. reset asserted mid-period → all reset values restored, with the next tick 4 cycles after deassert.
